// File: rtl/dino_motion_engine_if.sv
// Frame/control inputs and coordinate/status outputs exchanged between the
// VGA controller side (master) and the motion engine (slave).
interface dino_motion_engine_if;
  logic        screen_ready;
  logic        collision_detected;
  logic        start;
  logic        jump;
  logic [31:0] x_coor;
  logic [31:0] y_coor;
  logic [31:0] x_coor_obstacle;
  logic [31:0] y_coor_obstacle;
  logic [15:0] score;
  logic        game_over;
  logic [1:0]  state;

  modport master (
    output screen_ready, collision_detected, start, jump,
    input  x_coor, y_coor, x_coor_obstacle, y_coor_obstacle, score, game_over, state
  );
  modport slave (
    input  screen_ready, collision_detected, start, jump,
    output x_coor, y_coor, x_coor_obstacle, y_coor_obstacle, score, game_over, state
  );
endinterface

// File: rtl/dino_motion_engine.sv
// Per-frame game physics: run/jump/dead FSM, dino jump arc, scrolling
// obstacle with wrap-around and saturating score. All outputs registered.
module dino_motion_engine #(
  parameter int DINO_X       = 240,
  parameter int GROUND_Y     = 320,
  parameter int OBST_START_X = 680,
  parameter int OBST_SPEED   = 4,
  parameter int JUMP_V0      = 16,
  parameter int GRAVITY      = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  dino_motion_engine_if.slave  bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, JUMP = 2'd2, DEAD = 2'd3} state_t;

  localparam logic [11:0]        GROUND  = 12'(GROUND_Y);
  localparam logic signed [12:0] GROUND_S = 13'(GROUND_Y);
  localparam logic [10:0]        OBST_X0 = 11'(OBST_START_X);
  localparam logic [10:0]        SPEED   = 11'(OBST_SPEED);
  localparam logic signed [7:0]  V0      = 8'(JUMP_V0);
  localparam logic signed [7:0]  GRAV    = 8'(GRAVITY);

  state_t             state_q, state_d;
  logic [11:0]        y_q, y_d;
  logic [10:0]        xo_q, xo_d;
  logic [15:0]        score_q, score_d;
  logic signed [7:0]  vel, vel_d;
  logic               jp_q, jp_d;
  logic               sr_d;
  logic               tick;
  logic [10:0]        xo_step;
  logic [15:0]        score_step;
  logic signed [12:0] y_cand;

  assign tick = bus.screen_ready & ~sr_d;

  // Obstacle advance shared by RUN and JUMP; the reload case is where a
  // point is scored, so both values come out of one comparison.
  always_comb begin
    xo_step    = xo_q - SPEED;
    score_step = score_q;
    if (xo_q < SPEED) begin
      xo_step    = OBST_X0;
      score_step = (score_q == 16'hFFFF) ? score_q : score_q + 16'd1;
    end
  end

  // Screen y grows downward, so subtracting an upward velocity raises the dino.
  assign y_cand = $signed({1'b0, y_q}) - $signed({{5{vel[7]}}, vel});

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    xo_d    = xo_q;
    score_d = score_q;
    vel_d   = vel;
    jp_d    = jp_q;
    if (tick || state_q != RUN) jp_d = 1'b0;
    else if (bus.jump)          jp_d = 1'b1;
    if (tick) begin
      unique case (state_q)
        IDLE: if (bus.start) state_d = RUN;
        RUN: begin
          if (bus.collision_detected) state_d = DEAD;
          else begin
            xo_d    = xo_step;
            score_d = score_step;
            if (jp_q) begin
              vel_d   = V0;
              state_d = JUMP;
            end
          end
        end
        JUMP: begin
          if (bus.collision_detected) state_d = DEAD;
          else begin
            xo_d    = xo_step;
            score_d = score_step;
            if (vel < 0 && y_cand >= GROUND_S) begin
              y_d     = GROUND;
              vel_d   = '0;
              state_d = RUN;
            end else begin
              y_d   = y_cand[11:0];
              vel_d = vel - GRAV;
            end
          end
        end
        DEAD: begin
          if (bus.start) begin
            y_d     = GROUND;
            xo_d    = OBST_X0;
            score_d = '0;
            vel_d   = '0;
            state_d = RUN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      y_q     <= GROUND;
      xo_q    <= OBST_X0;
      score_q <= '0;
      vel     <= '0;
      jp_q    <= 1'b0;
      sr_d    <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      xo_q    <= xo_d;
      score_q <= score_d;
      vel     <= vel_d;
      jp_q    <= jp_d;
      sr_d    <= bus.screen_ready;
    end
  end

  assign bus.x_coor          = 32'(DINO_X);
  assign bus.y_coor          = {20'd0, y_q};
  assign bus.x_coor_obstacle = {21'd0, xo_q};
  assign bus.y_coor_obstacle = 32'(GROUND_Y);
  assign bus.score           = score_q;
  assign bus.game_over       = (state_q == DEAD);
  assign bus.state           = state_q;
endmodule

// File: doc/dino_motion_engine.md
Name: dino_motion_engine

Overview:
- Game-state engine that generates the dino and obstacle coordinates consumed by the VGA controller's x_coor/y_coor/x_coor_obstacle/y_coor_obstacle inputs.
- Consumes the controller's screen_ready frame pulse and collision_detected flag. Advances the game physics exactly once per frame.
- Owns the run/jump/game-over state machine, the dino jump physics, the scrolling obstacle with wrap-around, and the score counter.

Parameters:
- DINO_X, 240, fixed dino left x.
- GROUND_Y, 320, dino/obstacle bottom y.
- OBST_START_X, 680, obstacle reload x.
- OBST_SPEED, 4, obstacle pixels moved per frame.
- JUMP_V0, 16, initial upward velocity (px/frame); 1..127.
- GRAVITY, 1, velocity decrement per frame.

Ports:
- clk  in  1  100 MHz system clock.
- reset  in  1  synchronous, active-low reset.
- screen_ready  in  1  from the VGA controller; high for one 25 MHz period (4 clk cycles) per frame.
- collision_detected  in  1  from the VGA controller, combinational.
- start  in  1  level; begins or restarts the game.
- jump  in  1  level; jump button.
- x_coor  out  32  dino left x, zero-extended.
- y_coor  out  32  dino bottom y, zero-extended.
- x_coor_obstacle  out  32  obstacle left x, zero-extended.
- y_coor_obstacle  out  32  obstacle bottom y; constant GROUND_Y.
- score  out  16  number of obstacles passed; saturates at 16'hFFFF.
- game_over  out  1  high in the DEAD state.
- state  out  2  IDLE=0, RUN=1, JUMP=2, DEAD=3.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE, x_coor=DINO_X, y_coor=GROUND_Y, x_coor_obstacle=OBST_START_X, y_coor_obstacle=GROUND_Y.
  - score=0, game_over=0, vel=0, jump_pending=0, screen_ready_d=0.
  - Reset mid-jump or mid-game has the same effect.
- Frame tick:
  - tick = screen_ready & ~screen_ready_d, where screen_ready_d is registered on clk.
  - Exactly one tick per frame pulse, regardless of pulse width.
  - All position, velocity, score and state updates occur only on the clk edge where tick==1.
  - Exception: IDLE/DEAD→RUN on start, which is also tick-gated.
- jump_pending:
  - Set on any clk where jump==1 and state==RUN.
  - Cleared on every tick and whenever state!=RUN.
- IDLE: on tick with start==1 → RUN. Positions stay at their reset values. jump is ignored.
- RUN, on tick:
  - If collision_detected==1 → DEAD. No motion and no score change; collision has priority over every other action.
  - Else the obstacle moves (see Obstacle).
  - If jump_pending==1 → vel=JUMP_V0, state=JUMP, y unchanged on this launch tick.
- JUMP, on tick:
  - If collision_detected==1 → DEAD, with positions frozen.
  - Else the obstacle moves, and y_cand = y_coor − vel, computed as a signed 13-bit value.
    - If vel<0 and y_cand ≥ GROUND_Y → y_coor=GROUND_Y, vel=0, state=RUN (landing).
    - Otherwise y_coor=y_cand and vel=vel−GRAVITY.
  - vel is an 8-bit signed register.
  - jump input is ignored in JUMP; no double jump.
- Obstacle, applied in RUN/JUMP on a non-collision tick:
  - If x_coor_obstacle < OBST_SPEED → reload OBST_START_X and increment score (saturating).
  - Else x_coor_obstacle −= OBST_SPEED.
  - x_coor_obstacle never underflows.
- DEAD:
  - game_over=1; all coordinates and score hold.
  - On tick with start==1: reload all positions to their reset values, score=0, vel=0, state=RUN, game_over=0.
- start==1 while in RUN/JUMP has no effect.
- Latency: outputs are registered and change on the clk edge following detection of the rising edge of screen_ready. No combinational path exists from any input to any output.
- Jump arithmetic with defaults: launch tick, then 33 air ticks.
  - Peak y = GROUND_Y − 136 = 184, reached after air tick 16; air tick 17 holds at 184 with vel=0.
  - Landing occurs on air tick 33, with y=320 exactly.

Test Plan:
- Reset held low 3 clk with screen_ready pulsing → state=0, x_coor=240, y_coor=320, x_coor_obstacle=680, score=0, game_over=0. No change while IDLE with start=0.
- start=1 for one frame, then 10 frames → state=1, x_coor_obstacle=640. A 4-clk-wide screen_ready counts as 1 tick, not 4.
- 171 run frames after start, no collision → x_coor_obstacle=0 after frame 170, then 680 at frame 171, score=1.
- jump pulsed 1 clk mid-frame in RUN → next tick state=2 with y=320; air tick 1 y=304; air tick 16 y=184; air tick 17 y=184; air tick 33 y=320 with state=1. jump held high during air has no effect.
- collision_detected=1 on the same tick the obstacle would wrap → state=3, game_over=1, x_coor_obstacle unchanged, score unchanged. Coordinates are frozen for 5 further frames. start=1 → positions reload, score=0, state=1.
- reset low during air tick 10 → the following clk shows state=0, y_coor=320, vel=0, score=0.
